hd44780_byte_sender: RTL and testbench
======================================

// Module: hd44780_byte_sender
// PURPOSE
//  Parametrised successor to the nybble sender. Sends one HD44780 command or data byte per
//  request, over a 4-bit or 8-bit bus, with all bus timing derived from SYSFREQ.
//  Holds off the next request for the instruction execution time: long for clear/home, short otherwise.
//  Sits between the controller FSM and the LCD package pins. Tied to the wishbone syscon clock.
// PARAMETERS
//  SYSFREQ      12000000  system clock in Hz
//  BUS_WIDTH    4         LCD data bus width, 4 or 8; any other value is a synthesis $error
//  T_AS_NS      40        RS/data setup before E rises, in ns
//  T_EH_NS      450       E high pulse width, in ns
//  T_EL_NS      550       E low time after each pulse (E cycle >= 1000 ns), in ns
//  T_EXEC_US    37        execution wait for ordinary instructions and data, in us
//  T_LONG_US    1520      execution wait for clear display / return home, in us
// PORTS
//  CLK_I          in   1          system clock
//  RST_I          in   1          asynchronous, active-low reset
//  STB_I          in   1          request strobe; sampled only in IDLE
//  i_rs           in   1          register select for this transfer: 0 = command, 1 = data
//  i_data         in   8          byte to send
//  i_nybble_only  in   1          4-bit mode only: send i_data[7:4] as a single nybble (init sequence)
//  o_busy         out  1          high from the cycle after accept until the ack cycle, inclusive
//  o_ack          out  1          1-cycle done strobe, asserted at the end of the exec wait
//  o_lcd_data     out  BUS_WIDTH  LCD D7..D(8-BUS_WIDTH)
//  o_rs           out  1          LCD RS
//  o_e            out  1          LCD E
// BEHAVIOUR
//  - Cycle counts are computed from the timing parameters:
//    - SETUP_CYC, EH_CYC, EL_CYC = ceil(t * SYSFREQ / 1e9), EXEC_CYC and LONG_CYC = ceil(t * SYSFREQ / 1e6).
//    - Evaluate in 64-bit localparam arithmetic. Each count has a minimum of 1.
//    - Counter width = $clog2(LONG_CYC + 1).
//  - Reset (RST_I low, asynchronous): state = IDLE; o_e, o_rs, o_lcd_data, o_busy, o_ack all 0; counter = 0.
//    Reset in the middle of a transfer drops E immediately. No partial transfer resumes after release.
//  - All outputs are registered. No combinational path from any input to any output.
//  - Accept: on a rising edge in IDLE with STB_I = 1, latch i_rs, i_data and i_nybble_only.
//    - The next cycle: o_busy = 1, o_rs = latched rs, and o_lcd_data = first nybble (4-bit) or the byte (8-bit).
//    - Inputs are ignored while busy. A strobe held high across the ack cycle starts a new transfer
//      on the first IDLE edge after o_busy falls.
//  - FSM: IDLE -> SETUP(SETUP_CYC) -> EHIGH(EH_CYC, o_e = 1) -> ELOW(EL_CYC, o_e = 0, data held) ->
//    - if 4-bit, a second nybble is pending, and nybble_only = 0: load i_data[3:0] and return to SETUP;
//    - else -> EXEC(wait cycles) -> ACK(1 cycle, o_ack = 1, o_busy = 1) -> IDLE (o_busy = 0).
//  - Ordering and bus rules:
//    - 4-bit mode sends the high nybble first.
//    - o_rs and o_lcd_data are stable throughout SETUP, EHIGH and ELOW.
//    - In IDLE the outputs retain their last value, except o_e, which is always 0.
//  - EXEC length: LONG_CYC when rs = 0 and data[7:2] = 0 and data != 0 (clear display 0x01, return home 0x02/0x03).
//    Otherwise EXEC_CYC. This includes nybble_only and data writes.
//  - i_nybble_only is ignored in 8-bit mode; a full byte is sent.
//  - Data 0x00 with rs = 0 gets the short wait.
// TESTING (SYSFREQ = 12000000: SETUP = 1, EH = 6, EL = 7, EXEC = 444, LONG = 18240)
//  - 4-bit, rs = 1, data 0xB5:
//    - o_lcd_data = 0xB, then 0x5; two E pulses, each 6 cycles wide; E rises 14 cycles apart.
//    - o_rs = 1 throughout; o_ack comes 444 cycles after the second ELOW ends.
//  - 4-bit, rs = 0, data 0x01: same two pulses, then an 18240-cycle wait before o_ack. Repeat with 0x02 and 0x03.
//  - 4-bit, nybble_only = 1, data 0x30:
//    - exactly one E pulse with o_lcd_data = 0x3, then a 444-cycle wait.
//    - Strobes pulsed during busy are ignored (no extra E pulse).
//  - BUS_WIDTH = 8, data 0xA7, rs = 0: one E pulse with o_lcd_data = 0xA7; nybble_only = 1 changes nothing.
//  - STB_I held high for 3 transfers: back-to-back transfers; o_busy low exactly one cycle between them;
//    o_ack counts 3.
//  - Assert RST_I low while o_e = 1: o_e, o_busy and o_ack go to 0 immediately.
//    After release the sender sits in IDLE; a new strobe completes normally.

Source files
------------

// File: rtl/hd44780_byte_sender.sv
// HD44780 byte sender: one command/data byte per request over a 4- or 8-bit bus,
// with E timing and post-instruction execution waits derived from SYSFREQ.
module hd44780_byte_sender #(
    parameter int unsigned SYSFREQ   = 12000000,
    parameter int unsigned BUS_WIDTH = 4,
    parameter int unsigned T_AS_NS   = 40,
    parameter int unsigned T_EH_NS   = 450,
    parameter int unsigned T_EL_NS   = 550,
    parameter int unsigned T_EXEC_US = 37,
    parameter int unsigned T_LONG_US = 1520
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 STB_I,
    input  logic                 i_rs,
    input  logic [7:0]           i_data,
    input  logic                 i_nybble_only,
    output logic                 o_busy,
    output logic                 o_ack,
    output logic [BUS_WIDTH-1:0] o_lcd_data,
    output logic                 o_rs,
    output logic                 o_e,
    output logic [2:0]           state_dbg
);

    function automatic longint unsigned cycles(input longint unsigned t,
                                               input longint unsigned freq,
                                               input longint unsigned div);
        longint unsigned c;
        c = (t * freq + div - 64'd1) / div;
        return (c == 64'd0) ? 64'd1 : c;
    endfunction

    localparam longint unsigned SETUP_CYC = cycles(T_AS_NS,   SYSFREQ, 64'd1000000000);
    localparam longint unsigned EH_CYC    = cycles(T_EH_NS,   SYSFREQ, 64'd1000000000);
    localparam longint unsigned EL_CYC    = cycles(T_EL_NS,   SYSFREQ, 64'd1000000000);
    localparam longint unsigned EXEC_CYC  = cycles(T_EXEC_US, SYSFREQ, 64'd1000000);
    localparam longint unsigned LONG_CYC  = cycles(T_LONG_US, SYSFREQ, 64'd1000000);

    localparam int CW = $clog2(LONG_CYC + 64'd1);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 64'd1);
    localparam logic [CW-1:0] EH_LD    = CW'(EH_CYC - 64'd1);
    localparam logic [CW-1:0] EL_LD    = CW'(EL_CYC - 64'd1);
    localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 64'd1);
    localparam logic [CW-1:0] LONG_LD  = CW'(LONG_CYC - 64'd1);

    generate
        if (BUS_WIDTH != 4 && BUS_WIDTH != 8) begin : g_bad_width
            $error("hd44780_byte_sender: BUS_WIDTH must be 4 or 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EHIGH = 3'd2,
        ELOW  = 3'd3,
        EXEC  = 3'd4,
        ACK   = 3'd5
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [3:0]           low_q, low_n;
    logic                 second_q, second_n;
    logic                 long_q, long_n;
    logic                 busy_n, ack_n, e_n, rs_n;
    logic [BUS_WIDTH-1:0] lcd_n;

    assign state_dbg = state;

    // Outputs are computed for the next state and registered alongside it.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        low_n    = low_q;
        second_n = second_q;
        long_n   = long_q;
        busy_n   = o_busy;
        ack_n    = 1'b0;
        e_n      = 1'b0;
        rs_n     = o_rs;
        lcd_n    = o_lcd_data;
        unique case (state)
            IDLE: begin
                if (STB_I) begin
                    state_n  = SETUP;
                    cnt_n    = SETUP_LD;
                    busy_n   = 1'b1;
                    rs_n     = i_rs;
                    lcd_n    = i_data[7 -: BUS_WIDTH];
                    low_n    = i_data[3:0];
                    second_n = (BUS_WIDTH == 4) && !i_nybble_only;
                    long_n   = !i_rs && (i_data[7:2] == 6'd0) && (i_data != 8'd0);
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_n = EHIGH;
                    cnt_n   = EH_LD;
                    e_n     = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            EHIGH: begin
                if (cnt == '0) begin
                    state_n = ELOW;
                    cnt_n   = EL_LD;
                end else begin
                    cnt_n = cnt - 1'b1;
                    e_n   = 1'b1;
                end
            end
            ELOW: begin
                if (cnt == '0) begin
                    if (second_q) begin
                        state_n  = SETUP;
                        cnt_n    = SETUP_LD;
                        second_n = 1'b0;
                        lcd_n    = BUS_WIDTH'(low_q);
                    end else begin
                        state_n = EXEC;
                        cnt_n   = long_q ? LONG_LD : EXEC_LD;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    state_n = ACK;
                    ack_n   = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ACK: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state      <= IDLE;
            cnt        <= '0;
            low_q      <= '0;
            second_q   <= 1'b0;
            long_q     <= 1'b0;
            o_busy     <= 1'b0;
            o_ack      <= 1'b0;
            o_e        <= 1'b0;
            o_rs       <= 1'b0;
            o_lcd_data <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            low_q      <= low_n;
            second_q   <= second_n;
            long_q     <= long_n;
            o_busy     <= busy_n;
            o_ack      <= ack_n;
            o_e        <= e_n;
            o_rs       <= rs_n;
            o_lcd_data <= lcd_n;
        end
    end

endmodule

// File: tb/tb_hd44780_byte_sender.sv
// Bench for hd44780_byte_sender: a 4-bit and an 8-bit instance at 12 MHz, table vectors,
// random transfers against a pulse-list model, back-to-back strobes and mid-pulse reset.
module tb_hd44780_byte_sender;

    localparam int SETUP   = 1;
    localparam int EH      = 6;
    localparam int EL      = 7;
    localparam int E_CYCLE = SETUP + EH + EL;
    localparam int EXEC    = 444;
    localparam int LONG    = 18240;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stb4, stb8, rs_in, nyb_in;
    logic [7:0] data_in;

    logic       busy4, ack4, rs4, e4;
    logic [3:0] lcd4;
    logic [2:0] st4;
    logic       busy8, ack8, rs8, e8;
    logic [7:0] lcd8;
    logic [2:0] st8;

    bit         sel8;
    logic       cur_e, cur_busy, cur_ack, cur_rs;
    logic [7:0] cur_lcd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hd44780_byte_sender #(.BUS_WIDTH(4)) dut4 (
        .CLK_I(clk), .RST_I(rst_n), .STB_I(stb4), .i_rs(rs_in), .i_data(data_in),
        .i_nybble_only(nyb_in), .o_busy(busy4), .o_ack(ack4), .o_lcd_data(lcd4),
        .o_rs(rs4), .o_e(e4), .state_dbg(st4)
    );

    hd44780_byte_sender #(.BUS_WIDTH(8)) dut8 (
        .CLK_I(clk), .RST_I(rst_n), .STB_I(stb8), .i_rs(rs_in), .i_data(data_in),
        .i_nybble_only(nyb_in), .o_busy(busy8), .o_ack(ack8), .o_lcd_data(lcd8),
        .o_rs(rs8), .o_e(e8), .state_dbg(st8)
    );

    always_comb begin
        cur_e    = sel8 ? e8    : e4;
        cur_busy = sel8 ? busy8 : busy4;
        cur_ack  = sel8 ? ack8  : ack4;
        cur_rs   = sel8 ? rs8   : rs4;
        cur_lcd  = sel8 ? lcd8  : {4'h0, lcd4};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: how many E pulses a request produces and how long the execution wait is.
    function automatic int model_pulses(input bit w8, input logic nyb);
        return (w8 || nyb) ? 1 : 2;
    endfunction

    function automatic int model_wait(input logic rs, input logic [7:0] d);
        return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? LONG : EXEC;
    endfunction

    task automatic set_stb(input bit w8, input logic v);
        if (w8) stb8 = v;
        else    stb4 = v;
    endtask

    // One transfer; cycle k = 0 is the first cycle after the accepting edge.
    task automatic do_xfer(input string tag, input bit w8, input logic rs, input logic [7:0] d,
                           input logic nyb, input bit poke, input int exp_n, input int exp_wait);
        logic [7:0] exp_q[$];
        logic [7:0] exp_v;
        int exp_ack, ack_at, rises, e_cycles;
        bit rs_bad, busy_bad;
        logic prev_e;
        for (int j = 0; j < exp_n; j++)
            exp_q.push_back(w8 ? d : (j == 0 ? {4'h0, d[7:4]} : {4'h0, d[3:0]}));
        exp_ack  = E_CYCLE * exp_n + exp_wait;
        ack_at   = -1;
        rises    = 0;
        e_cycles = 0;
        rs_bad   = 0;
        busy_bad = 0;
        prev_e   = 1'b0;
        sel8     = w8;
        @(negedge clk);
        rs_in = rs; data_in = d; nyb_in = nyb;
        set_stb(w8, 1'b1);
        @(negedge clk);
        set_stb(w8, 1'b0);
        for (int k = 0; k < exp_ack + 40 && ack_at < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (cur_busy !== 1'b1) busy_bad = 1;
            if (cur_rs !== rs) rs_bad = 1;
            if (cur_e === 1'b1) e_cycles++;
            if (cur_e === 1'b1 && prev_e !== 1'b1) begin
                check($sformatf("%s rise%0d_cycle", tag, rises), k, 1 + rises * E_CYCLE);
                if (exp_q.size() == 0) begin
                    check($sformatf("%s extra_pulse", tag), rises + 1, exp_n);
                end else begin
                    exp_v = exp_q.pop_front();
                    check($sformatf("%s pulse%0d_data", tag, rises), cur_lcd, exp_v);
                end
                rises++;
            end
            if (cur_ack === 1'b1) ack_at = k;
            prev_e = cur_e;
            if (poke) set_stb(w8, (k == 3 || k == exp_ack - 3));
        end
        set_stb(w8, 1'b0);
        check($sformatf("%s ack_cycle", tag), ack_at, exp_ack);
        check($sformatf("%s pulse_count", tag), rises, exp_n);
        check($sformatf("%s e_high_cycles", tag), e_cycles, EH * exp_n);
        check($sformatf("%s pending_pulses", tag), exp_q.size(), 0);
        check($sformatf("%s rs_stable", tag), rs_bad, 0);
        check($sformatf("%s busy_held", tag), busy_bad, 0);
        @(negedge clk);
        check($sformatf("%s busy_after_ack", tag), cur_busy, 0);
        check($sformatf("%s ack_one_cycle", tag), cur_ack, 0);
        repeat (3) @(negedge clk);
        check($sformatf("%s stays_idle", tag), {cur_busy, cur_e}, 2'b00);
    endtask

    typedef struct {
        bit         w8;
        logic       rs;
        logic [7:0] d;
        logic       nyb;
        bit         poke;
        int         exp_n;
        int         exp_wait;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int acks, last_ack, low_run, gaps, waited;
        bit started, seen_e;
        logic [7:0] rd;
        logic rrs, rnyb;
        bit rw8;

        vecs[0] = '{0, 1'b1, 8'hB5, 1'b0, 0, 2, EXEC};
        vecs[1] = '{0, 1'b0, 8'h01, 1'b0, 0, 2, LONG};
        vecs[2] = '{0, 1'b0, 8'h02, 1'b0, 0, 2, LONG};
        vecs[3] = '{0, 1'b0, 8'h03, 1'b0, 0, 2, LONG};
        vecs[4] = '{0, 1'b0, 8'h30, 1'b1, 1, 1, EXEC};
        vecs[5] = '{1, 1'b0, 8'hA7, 1'b0, 0, 1, EXEC};
        vecs[6] = '{1, 1'b0, 8'hA7, 1'b1, 1, 1, EXEC};
        vecs[7] = '{0, 1'b0, 8'h00, 1'b0, 0, 2, EXEC};
        vecs[8] = '{0, 1'b1, 8'h01, 1'b0, 0, 2, EXEC};
        vecs[9] = '{0, 1'b0, 8'h04, 1'b0, 0, 2, EXEC};

        rst_n = 1'b0; stb4 = 1'b0; stb8 = 1'b0; rs_in = 1'b0; data_in = 8'h00; nyb_in = 1'b0;
        sel8 = 0;
        repeat (3) @(negedge clk);
        check("reset_4bit_outputs", {busy4, ack4, rs4, e4, lcd4}, 8'h00);
        check("reset_8bit_outputs", {busy8, ack8, rs8, e8, lcd8}, 12'h000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++)
            do_xfer($sformatf("vec%0d", i), vecs[i].w8, vecs[i].rs, vecs[i].d, vecs[i].nyb,
                    vecs[i].poke, vecs[i].exp_n, vecs[i].exp_wait);

        for (int i = 0; i < 8; i++) begin
            rw8  = bit'($urandom_range(0, 1));
            rrs  = 1'($urandom_range(0, 1));
            rnyb = 1'($urandom_range(0, 1));
            rd   = 8'($urandom_range(0, 255));
            if (!rrs && rd inside {[8'h01:8'h03]}) rd = rd | 8'h10;
            do_xfer($sformatf("rnd%0d", i), rw8, rrs, rd, rnyb, bit'($urandom_range(0, 1)),
                    model_pulses(rw8, rnyb), model_wait(rrs, rd));
        end

        // Strobe held high: three back-to-back transfers with one idle cycle between each.
        sel8 = 0;
        @(negedge clk);
        rs_in = 1'b1; data_in = 8'h48; nyb_in = 1'b0;
        stb4 = 1'b1;
        acks = 0; last_ack = -1; low_run = 0; gaps = 0; started = 0;
        for (int k = 0; k < 3 * 600 && acks < 3; k++) begin
            @(negedge clk);
            if (cur_busy === 1'b1) begin
                if (started && low_run > 0) begin
                    check($sformatf("b2b gap%0d_len", gaps), low_run, 1);
                    gaps++;
                end
                started = 1;
                low_run = 0;
            end else if (started) begin
                low_run++;
            end
            if (cur_ack === 1'b1) begin
                if (last_ack >= 0)
                    check($sformatf("b2b ack%0d_spacing", acks), k - last_ack, 2 * E_CYCLE + EXEC + 2);
                last_ack = k;
                acks++;
                if (acks == 3) stb4 = 1'b0;
            end
        end
        check("b2b ack_count", acks, 3);
        check("b2b gap_count", gaps, 2);
        repeat (3) @(negedge clk);
        check("b2b idle_after", cur_busy, 0);

        // Reset while E is high.
        sel8 = 0;
        @(negedge clk);
        rs_in = 1'b1; data_in = 8'h5A; nyb_in = 1'b0;
        stb4 = 1'b1;
        @(negedge clk);
        stb4 = 1'b0;
        seen_e = 0;
        for (int k = 0; k < 40 && !seen_e; k++) begin
            if (e4 === 1'b1) seen_e = 1;
            else @(negedge clk);
        end
        check("rst e_reached", seen_e, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst e_drop", e4, 0);
        check("rst busy_drop", busy4, 0);
        check("rst ack_drop", ack4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        waited = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy4 !== 1'b0 || e4 !== 1'b0 || ack4 !== 1'b0) waited++;
        end
        check("rst no_resume", waited, 0);
        do_xfer("post_rst", 0, 1'b0, 8'h28, 1'b0, 0, 2, EXEC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
